// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the async FIFO.
// Pops first-word-fall-through words from the FIFO read port and presents
// them as a registered valid/ready stream through a 2-entry skid buffer.
// The FIFO pop strobe depends only on rempty and registered occupancy, so
// m_ready never reaches rinc combinationally.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to implement the
// delivered-word counter on word_cnt; otherwise word_cnt is tied to 0.
module fifo_rd_stream #(
   parameter int DSIZE = 6,
   parameter int CNTW  = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNTW-1:0]  word_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [DSIZE-1:0] e0;
   logic [DSIZE-1:0] e1;
   logic [DSIZE-1:0] e0_next;
   logic [DSIZE-1:0] e1_next;
   logic             pop;
   logic             xfer;

   // Pop whenever the FIFO has a word and the skid buffer has a free slot.
   assign rinc    = ~rrst & ~rempty & (state != TWO);
   assign pop     = rinc;
   assign m_valid = (state != EMPTY);
   assign m_data  = e0;
   assign xfer    = m_valid & m_ready;

   // Occupancy register and buffer entries; reset discards buffered words.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state <= EMPTY;
         e0    <= '0;
         e1    <= '0;
      end else begin
         state <= state_next;
         e0    <= e0_next;
         e1    <= e1_next;
      end
   end

   // Next occupancy and entry contents from pop/transfer combination.
   always_comb begin
      state_next = state;
      e0_next    = e0;
      e1_next    = e1;
      case (state)
         EMPTY: begin
            if (pop) begin
               state_next = ONE;
               e0_next    = rdata;
            end
         end
         ONE: begin
            if (pop && xfer) begin
               e0_next = rdata;
            end else if (pop) begin
               state_next = TWO;
               e1_next    = rdata;
            end else if (xfer) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            // rinc is low here, so only a downstream transfer moves data
            if (xfer) begin
               state_next = ONE;
               e0_next    = e1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [CNTW-1:0] cnt;

   // Delivered-word counter, wraps naturally at 2^CNTW.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt <= '0;
      end else if (xfer) begin
         cnt <= cnt + CNTW'(1);
      end
   end

   assign word_cnt = cnt;
`else
   assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream (DSIZE=6, CNTW=4).
// The FIFO is modelled as a queue; every word written to it is expected on
// the stream in the same order. A negedge monitor compares stream transfers
// against the expected queue and tracks the delivered-word count.
module tb_fifo_rd_stream;

   logic       rclk;
   logic       rrst;
   logic [5:0] rdata;
   logic       rempty;
   logic       rinc;
   logic [5:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [3:0] word_cnt;

   fifo_rd_stream #(.DSIZE(6), .CNTW(4)) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rdata   (rdata),
      .rempty  (rempty),
      .rinc    (rinc),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .word_cnt(word_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int         tests     = 0;
   int         fails     = 0;
   int         exp_cnt   = 0;
   int         pop_count = 0;
   logic       pop_seen  = 1'b0;
   logic [5:0] fifo[$];
   logic [5:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] exp_wc(input int n);
`ifdef FIFO_RD_STREAM_CNT_EN
      return 32'(n % 16);
`else
      return 32'(n * 0);
`endif
   endfunction

   task automatic drive();
      rempty = (fifo.size() == 0);
      rdata  = (fifo.size() == 0) ? 6'd0 : fifo[0];
   endtask

   task automatic step();
      @(posedge rclk);
      #1;
      if (pop_seen && fifo.size() > 0) begin
         void'(fifo.pop_front());
         pop_count++;
      end
      pop_seen = 1'b0;
      drive();
   endtask

   task automatic wr(input logic [5:0] d);
      fifo.push_back(d);
      exp_q.push_back(d);
      drive();
   endtask

   task automatic reset_dut();
      #2;
      rrst = 1'b1;
      fifo.delete();
      exp_q.delete();
      exp_cnt  = 0;
      pop_seen = 1'b0;
      drive();
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      @(posedge rclk);
      @(posedge rclk);
      #3;
      rrst = 1'b0;
   endtask

   task automatic drain(input int max);
      m_ready = 1'b1;
      for (int i = 0; i < max && (exp_q.size() != 0 || fifo.size() != 0); i++) step();
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      step();
      @(negedge rclk);
      chk("drain_idle_valid", 32'(m_valid), 32'd0);
      step();
   endtask

   // Monitor: underflow, counter and in-order delivery on every falling edge.
   always @(negedge rclk) begin
      pop_seen = rinc;
      if (!rrst) begin
         chk("underflow", 32'(rinc & rempty), 32'd0);
         chk("word_cnt", 32'(word_cnt), exp_wc(exp_cnt));
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 32'(m_data), 32'h100);
            else chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            exp_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_r[5];
      int exp_v[5];
      int written;
      int p0;
      exp_r = '{1, 1, 1, 0, 0};
      exp_v = '{0, 1, 1, 1, 0};

      rrst    = 1'b1;
      m_ready = 1'b0;
      drive();
      @(posedge rclk);
      @(posedge rclk);
      #1;
      chk("init_m_valid", 32'(m_valid), 32'd0);
      chk("init_m_data", 32'(m_data), 32'd0);
      chk("init_word_cnt", 32'(word_cnt), 32'd0);
      chk("init_rinc", 32'(rinc), 32'd0);
      #3;
      rrst = 1'b0;
      step();

      // Test 1: three preloaded words at full rate.
      m_ready = 1'b1;
      wr(6'h01); wr(6'h02); wr(6'h03);
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         chk("t1_rinc", 32'(rinc), 32'(exp_r[i]));
         chk("t1_m_valid", 32'(m_valid), 32'(exp_v[i]));
         step();
      end
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("t1_word_cnt", 32'(word_cnt), 32'd3);
`else
      chk("t1_word_cnt", 32'(word_cnt), 32'd0);
`endif

      // Test 2: back-pressure fills the skid buffer with exactly two words.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(6'($urandom_range(0, 63)));
      p0 = pop_count;
      begin
         logic [5:0] first;
         first = fifo[0];
         repeat (5) step();
         @(negedge rclk);
         chk("t2_pops", 32'(pop_count - p0), 32'd2);
         chk("t2_rinc", 32'(rinc), 32'd0);
         chk("t2_m_valid", 32'(m_valid), 32'd1);
         chk("t2_m_data", 32'(m_data), 32'(first));
      end
      step();
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         chk("t2_no_gap", 32'(m_valid), 32'd1);
         step();
      end
      drain(20);

      // Test 3: m_ready toggling every cycle, 8 words trickling in.
      written = 0;
      for (int i = 0; i < 80 && (written < 8 || exp_q.size() != 0); i++) begin
         m_ready = ~m_ready;
         if (written < 8 && $urandom_range(0, 1) == 1) begin
            wr(6'($urandom_range(0, 63)));
            written++;
         end
         step();
      end
      chk("t3_written", 32'(written), 32'd8);
      drain(40);

      // Test 4: asynchronous reset with two words buffered.
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(6'($urandom_range(1, 63)));
      repeat (4) step();
      reset_dut();
      step();
      m_ready = 1'b1;
      wr(6'h2a); wr(6'h15); wr(6'h3f);
      drain(20);

      // Test 5: 17 randomized transfers through a 4-bit counter.
      reset_dut();
      step();
      written = 0;
      for (int i = 0; i < 200 && (written < 17 || exp_q.size() != 0); i++) begin
         m_ready = 1'($urandom_range(0, 1));
         if (written < 17 && $urandom_range(0, 2) != 0) begin
            wr(6'($urandom_range(0, 63)));
            written++;
         end
         step();
      end
      drain(40);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("t5_word_cnt", 32'(word_cnt), 32'd1);
`else
      chk("t5_word_cnt", 32'(word_cnt), 32'd0);
`endif

      // Test 6: idle FIFO, then a single word.
      reset_dut();
      step();
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge rclk);
         chk("t6_idle", 32'({rinc, m_valid}), 32'd0);
         step();
      end
      p0 = pop_count;
      wr(6'($urandom_range(0, 63)));
      drain(10);
      chk("t6_pops", 32'(pop_count - p0), 32'd1);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("t6_word_cnt", 32'(word_cnt), 32'd1);
`else
      chk("t6_word_cnt", 32'(word_cnt), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the team's async FIFO; sits entirely in the read clock domain.
- Pops words from the FIFO read port (rdata/rinc/rempty) and presents them as a registered valid/ready stream to downstream logic.
- A 2-entry skid buffer sustains one word per cycle while keeping m_ready off the combinational rinc path.
- Optionally counts delivered words.

Parameters:
DSIZE, 6, data width in bits; must match the FIFO DSIZE
CNTW, 16, width of the delivered-word counter

Ports:
rclk  input  1  read-domain clock; all state on rising edge
rrst  input  1  asynchronous active-high reset; FIFO rrst_n is driven as ~rrst at top level
rdata  input  DSIZE  FIFO read data, first-word-fall-through (valid whenever rempty=0)
rempty  input  1  FIFO empty flag, registered in rclk domain
rinc  output  1  FIFO pop strobe; pops head word at the rclk edge where rinc=1
m_data  output  DSIZE  stream data (head of skid buffer)
m_valid  output  1  stream valid
m_ready  input  1  stream ready; transfer on an edge where m_valid=1 and m_ready=1
word_cnt  output  CNTW  count of completed stream transfers (see Optional Feature)

Behaviour:
- Reset (rrst=1, async): occupancy=0, both buffer entries=0, m_valid=0, m_data=0, word_cnt=0; rinc forced 0 while rrst=1.
- Buffer: entries e0 (head) and e1; occupancy state EMPTY/ONE/TWO.
- rinc = ~rrst & ~rempty & (state != TWO). Purely combinational from rempty and registered state; m_ready never feeds rinc.
- pop = rinc; xfer = m_valid & m_ready. m_valid = (state != EMPTY), registered. m_data = e0.
- EMPTY: pop -> ONE, e0<=rdata. No pop -> stay.
- ONE:
  - pop & xfer -> ONE, e0<=rdata.
  - pop & ~xfer -> TWO, e1<=rdata.
  - ~pop & xfer -> EMPTY.
  - Otherwise hold.
- TWO (rinc=0):
  - xfer -> ONE, e0<=e1.
  - Otherwise hold; e0/e1 stable.
- Latency: word at FIFO head with rempty=0 at edge N appears on m_data with m_valid=1 after edge N (one cycle).
- Throughput: one word per rclk with m_ready held high and FIFO non-empty.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_valid hold stable; word order is preserved exactly; no word is dropped or duplicated.
- rempty rising in the same cycle as a pop is handled naturally: rinc deasserts the following cycle. The block never pops when rempty=1 (no underflow).
- m_ready may toggle arbitrarily; the block has no dependency on it beyond xfer.
- Reset mid-operation: buffered words are discarded; m_valid drops asynchronously. After release, operation restarts from EMPTY.
- word_cnt: increments by 1 on each xfer; wraps from 2^CNTW-1 to 0.

Optional Feature:
- Macro FIFO_RD_STREAM_CNT_EN.
- Defined: word_cnt is implemented as described above.
- Undefined: no counter register; word_cnt is tied to 0. Port list is unchanged.

Test Plan:
1. Reset, then FIFO preloaded (DSIZE=6) with 0x01,0x02,0x03 and m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x01,0x02,0x03 on 3 consecutive cycles starting one cycle after the first pop; m_valid then 0; word_cnt=3.
2. FIFO holds 5 words, m_ready=0 -> exactly 2 pops, state TWO, rinc=0, m_data=first word stable. Raise m_ready -> all 5 words delivered in order, no gaps once flowing.
3. m_ready toggled every cycle while 8 words stream -> 8 transfers, order intact, no duplicates; rinc never high while rempty=1.
4. Assert rrst asynchronously mid-stream with 2 words buffered -> m_valid=0 and word_cnt=0 immediately without a clock edge; after release, no stale word appears.
5. CNTW=4, FIFO_RD_STREAM_CNT_EN defined, 17 transfers -> word_cnt=1. Rebuild without the macro -> word_cnt=0 throughout.
6. FIFO empty for 20 cycles -> rinc=0 and m_valid=0. Single write arrives -> one pop, one transfer, word_cnt=1.
